// File: rtl/dram_arbiter.sv
// dram_arbiter: registered round-robin arbiter sharing one 1024x32
// distributed RAM (sync write, async read) between two masters.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   mX_req/we/addr/wdata master X request bundle, held until mX_gnt
//   mX_gnt               master X access performed this cycle
//   mX_rvalid/rdata      master X read data, one cycle after the grant
//   mem_we/addr/d        RAM write enable, address, write data
//   mem_spo              RAM asynchronous read data
module dram_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_d,
  input  logic [DATA_W-1:0] mem_spo
);

  typedef enum logic [1:0] {
    IDLE,
    SERVE0,
    SERVE1
  } state_t;

  state_t state;
  state_t state_d;
  logic   last;
  logic   last_d;
  logic   rd0;
  logic   rd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      last  <= 1'b1;
    end else begin
      state <= state_d;
      last  <= last_d;
    end
  end

  // On a tie the master that was not served most recently wins.
  always_comb begin
    state_d = IDLE;
    last_d  = last;
    unique case (1'b1)
      (m0_req && !m1_req): state_d = SERVE0;
      (!m0_req && m1_req): state_d = SERVE1;
      (m0_req && m1_req):  state_d = last ? SERVE0 : SERVE1;
      default:             state_d = IDLE;
    endcase
    if (state_d == SERVE0) last_d = 1'b0;
    if (state_d == SERVE1) last_d = 1'b1;
  end

  assign m0_gnt = (state == SERVE0);
  assign m1_gnt = (state == SERVE1);

  // RAM port is driven from the registered grant only, so mem_we
  // can never assert outside a serve cycle.
  always_comb begin
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_d    = '0;
    unique case (state)
      SERVE0: begin
        mem_we   = m0_we;
        mem_addr = m0_addr;
        mem_d    = m0_wdata;
      end
      SERVE1: begin
        mem_we   = m1_we;
        mem_addr = m1_addr;
        mem_d    = m1_wdata;
      end
      default: begin
        mem_we   = 1'b0;
        mem_addr = '0;
        mem_d    = '0;
      end
    endcase
  end

  assign rd0 = m0_gnt && !m0_we;
  assign rd1 = m1_gnt && !m1_we;

  // Async read data is captured at the edge closing the grant cycle;
  // a read caught by reset is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
      m0_rdata  <= '0;
      m1_rdata  <= '0;
    end else begin
      m0_rvalid <= rd0;
      m1_rvalid <= rd1;
      if (rd0) m0_rdata <= mem_spo;
      if (rd1) m1_rdata <= mem_spo;
    end
  end

endmodule

// File: tb/tb_dram_arbiter.sv
// tb_dram_arbiter: directed plus random stimulus for dram_arbiter,
// checked against a round-robin reference model and a shadow memory.
module tb_dram_arbiter;

  localparam int AW = 10;
  localparam int DW = 32;
  localparam int N  = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          m0_req, m0_we, m1_req, m1_we;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [DW-1:0] m0_wdata, m1_wdata;
  logic          m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_d, mem_spo;

  dram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid),
    .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid),
    .m1_rdata(m1_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_d(mem_d), .mem_spo(mem_spo)
  );

  always #5 clk = ~clk;

  // RAM instance: synchronous write, asynchronous read.
  logic [DW-1:0] ram [N];
  logic          ram_clr;
  assign mem_spo = ram[mem_addr];
  always @(posedge clk) begin
    if (ram_clr) begin
      for (int i = 0; i < N; i++) ram[i] <= '0;
    end else if (mem_we) begin
      ram[mem_addr] <= mem_d;
    end
  end

  // Reference model state.
  int            checks = 0;
  int            errors = 0;
  logic [1:0]    eg;
  logic [1:0]    erv;
  logic [DW-1:0] erd [2];
  int            last_srv;
  logic [DW-1:0] ref_mem [N];
  int            seq [$];
  logic [1:0]    need_new;

  task automatic chk(input string tag,
                     input logic [DW-1:0] got,
                     input logic [DW-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic set0(input logic r, input logic w,
                      input logic [AW-1:0] a,
                      input logic [DW-1:0] d);
    m0_req = r; m0_we = w; m0_addr = a; m0_wdata = d;
  endtask

  task automatic set1(input logic r, input logic w,
                      input logic [AW-1:0] a,
                      input logic [DW-1:0] d);
    m1_req = r; m1_we = w; m1_addr = a; m1_wdata = d;
  endtask

  // One clock cycle: inputs for this cycle are already applied.
  task automatic cyc();
    logic [1:0] ng;
    #1;
    if (eg[0]) begin
      chk("mem_we_s0", {31'b0, mem_we}, {31'b0, m0_we});
      chk("mem_addr_s0", {22'b0, mem_addr}, {22'b0, m0_addr});
      chk("mem_d_s0", mem_d, m0_wdata);
    end else if (eg[1]) begin
      chk("mem_we_s1", {31'b0, mem_we}, {31'b0, m1_we});
      chk("mem_addr_s1", {22'b0, mem_addr}, {22'b0, m1_addr});
      chk("mem_d_s1", mem_d, m1_wdata);
    end else begin
      chk("mem_we_idle", {31'b0, mem_we}, 32'd0);
      chk("mem_addr_idle", {22'b0, mem_addr}, 32'd0);
      chk("mem_d_idle", mem_d, 32'd0);
    end
    erv = '0;
    if (eg[0] && !m0_we && !rst) begin
      erv[0] = 1'b1; erd[0] = ref_mem[m0_addr];
    end
    if (eg[1] && !m1_we && !rst) begin
      erv[1] = 1'b1; erd[1] = ref_mem[m1_addr];
    end
    if (rst) begin
      erd[0] = '0; erd[1] = '0;
    end
    if (eg[0] && m0_we) ref_mem[m0_addr] = m0_wdata;
    if (eg[1] && m1_we) ref_mem[m1_addr] = m1_wdata;
    if (eg[0]) seq.push_back(0);
    if (eg[1]) seq.push_back(1);
    ng = 2'b00;
    if (rst) begin
      last_srv = 1;
    end else begin
      if (m0_req && m1_req)
        ng = (last_srv == 0) ? 2'b10 : 2'b01;
      else if (m0_req) ng = 2'b01;
      else if (m1_req) ng = 2'b10;
      if (ng[0]) last_srv = 0;
      if (ng[1]) last_srv = 1;
    end
    eg = ng;
    @(posedge clk);
    #1;
    chk("m0_gnt", {31'b0, m0_gnt}, {31'b0, eg[0]});
    chk("m1_gnt", {31'b0, m1_gnt}, {31'b0, eg[1]});
    chk("m0_rvalid", {31'b0, m0_rvalid}, {31'b0, erv[0]});
    chk("m1_rvalid", {31'b0, m1_rvalid}, {31'b0, erv[1]});
    chk("m0_rdata", m0_rdata, erd[0]);
    chk("m1_rdata", m1_rdata, erd[1]);
  endtask

  function automatic logic [AW-1:0] rnd_addr();
    int s;
    s = $urandom_range(0, 11);
    if (s == 0) return 10'h3FF;
    if (s == 1) return 10'h000;
    return AW'($urandom_range(0, 7));
  endfunction

  initial begin
    rst = 1'b1; ram_clr = 1'b1;
    set0(0, 0, 0, 0); set1(0, 0, 0, 0);
    eg = '0; erv = '0; erd[0] = '0; erd[1] = '0;
    last_srv = 1; need_new = '0;
    for (int i = 0; i < N; i++) ref_mem[i] = '0;
    @(posedge clk); @(posedge clk); #1;
    ram_clr = 1'b0;
    chk("rst_gnt0", {31'b0, m0_gnt}, 32'd0);
    chk("rst_gnt1", {31'b0, m1_gnt}, 32'd0);
    chk("rst_rv0", {31'b0, m0_rvalid}, 32'd0);
    chk("rst_rv1", {31'b0, m1_rvalid}, 32'd0);
    chk("rst_we", {31'b0, mem_we}, 32'd0);
    chk("rst_addr", {22'b0, mem_addr}, 32'd0);
    chk("rst_rd0", m0_rdata, 32'd0);
    chk("rst_rd1", m1_rdata, 32'd0);
    rst = 1'b0;
    cyc(); cyc();

    // m0 write then read back at 0x005.
    set0(1, 1, 10'h005, 32'hDEADBEEF); cyc();
    chk("wr_gnt", {31'b0, m0_gnt}, 32'd1);
    m0_req = 1'b0; cyc();
    set0(1, 0, 10'h005, 32'h0); cyc();
    m0_req = 1'b0; cyc();
    chk("rd_rvalid", {31'b0, m0_rvalid}, 32'd1);
    chk("rd_data", m0_rdata, 32'hDEADBEEF);
    cyc();

    // Tie straight after reset: m0 first, then m1.
    rst = 1'b1; cyc(); rst = 1'b0;
    set0(1, 0, 10'h005, 32'h0);
    set1(1, 0, 10'h006, 32'h0); cyc();
    chk("tie_g0", {31'b0, m0_gnt}, 32'd1);
    m0_req = 1'b0; cyc();
    chk("tie_g1", {31'b0, m1_gnt}, 32'd1);
    chk("tie_rv0", {31'b0, m0_rvalid}, 32'd1);
    m1_req = 1'b0; cyc();
    chk("tie_rv1", {31'b0, m1_rvalid}, 32'd1);
    chk("tie_rv0_off", {31'b0, m0_rvalid}, 32'd0);

    // Sustained contention: six alternating grants.
    seq.delete();
    set0(1, 0, 10'h005, 32'h0);
    set1(1, 0, 10'h3FF, 32'h0);
    for (int i = 0; i < 6; i++) cyc();
    m0_req = 1'b0; m1_req = 1'b0; cyc(); cyc();
    chk("alt_len", 32'(seq.size()), 32'd6);
    for (int i = 0; i < 6 && i < seq.size(); i++)
      chk("alt_order", 32'(seq[i]), 32'(i % 2));

    // m1 write at top word, m0 reads it the following cycle.
    set1(1, 1, 10'h3FF, 32'h12345678); cyc();
    m1_req = 1'b0;
    set0(1, 0, 10'h3FF, 32'h0); cyc();
    m0_req = 1'b0; cyc();
    chk("raw_data", m0_rdata, 32'h12345678);
    set0(1, 1, 10'h000, 32'hA5A5A5A5); cyc();
    m0_req = 1'b0; cyc();
    set0(1, 0, 10'h3FF, 32'h0); cyc();
    m0_req = 1'b0; cyc();
    chk("top_kept", m0_rdata, 32'h12345678);

    // Reset during an m1 read grant.
    set1(1, 0, 10'h3FF, 32'h0); cyc();
    m1_req = 1'b0; rst = 1'b1; cyc();
    rst = 1'b0;
    chk("mrst_gnt1", {31'b0, m1_gnt}, 32'd0);
    cyc();
    chk("mrst_rv1", {31'b0, m1_rvalid}, 32'd0);
    set0(1, 0, 10'h001, 32'h0);
    set1(1, 0, 10'h002, 32'h0); cyc();
    chk("mrst_tie", {31'b0, m0_gnt}, 32'd1);
    m0_req = 1'b0; cyc();
    m1_req = 1'b0; cyc(); cyc();

    // Random traffic with occasional reset pulses.
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 59) == 0);
      if (need_new[0]) begin
        m0_we = 1'($urandom_range(0, 1));
        m0_addr = rnd_addr(); m0_wdata = $urandom;
        need_new[0] = 1'b0;
      end
      if (eg[0]) begin
        m0_req = ($urandom_range(0, 2) != 0);
        need_new[0] = m0_req;
      end else if (!m0_req && $urandom_range(0, 2) != 0) begin
        set0(1, 1'($urandom_range(0, 1)), rnd_addr(), $urandom);
      end
      if (need_new[1]) begin
        m1_we = 1'($urandom_range(0, 1));
        m1_addr = rnd_addr(); m1_wdata = $urandom;
        need_new[1] = 1'b0;
      end
      if (eg[1]) begin
        m1_req = ($urandom_range(0, 2) != 0);
        need_new[1] = m1_req;
      end else if (!m1_req && $urandom_range(0, 2) != 0) begin
        set1(1, 1'($urandom_range(0, 1)), rnd_addr(), $urandom);
      end
      cyc();
    end
    rst = 1'b0;
    set0(0, 0, 0, 0); set1(0, 0, 0, 0);
    cyc(); cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
